// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu pipeline: encodings, ALU operations,
// operand selects, pipeline-register layouts and small decode helpers.
package cpu_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_e;
    typedef enum logic [1:0] {SRC_B_RS2, SRC_B_IMM, SRC_B_FOUR} src_b_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        alu_op_e     alu_op;
        src_a_e      src_a;
        src_b_e      src_b;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_write;
    } mem_wb_t;

    // Shift-right returns SRL; the caller upgrades to SRA from funct7.
    function automatic alu_op_e base_op(input logic [2:0] f3);
        case (f3)
            F3_ADD:  return ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e muldiv_op(input logic [2:0] f3);
        case (f3)
            3'd0:    return ALU_MUL;
            3'd1:    return ALU_MULH;
            3'd2:    return ALU_MULHSU;
            3'd3:    return ALU_MULHU;
            3'd4:    return ALU_DIV;
            3'd5:    return ALU_DIVU;
            3'd6:    return ALU_REM;
            default: return ALU_REMU;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_LB:   return {{24{d[7]}}, d[7:0]};
            F3_LH:   return {{16{d[15]}}, d[15:0]};
            F3_LBU:  return {24'd0, d[7:0]};
            F3_LHU:  return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/cpu_alu.sv
// Single-cycle integer ALU: RV32I base operations plus multiply/divide,
// with the architectural divide-by-zero and signed-overflow results.
module cpu_alu
    import cpu_pkg::*;
(
    input  alu_op_e     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] y_o
);

    logic [63:0] prod;
    logic        div_zero;
    logic        div_ovf;

    assign div_zero = (b_i == 32'd0);
    assign div_ovf  = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);

    // Full 64-bit product with operand signedness chosen by the high-half variant.
    always_comb begin
        case (op_i)
            ALU_MULH:   prod = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
            ALU_MULHSU: prod = $signed({{32{a_i[31]}}, a_i}) * $signed({32'd0, b_i});
            default:    prod = {32'd0, a_i} * {32'd0, b_i};
        endcase
    end

    // Result select; divider corner cases bypass the divide operator.
    always_comb begin
        case (op_i)
            ALU_ADD:    y_o = a_i + b_i;
            ALU_SUB:    y_o = a_i - b_i;
            ALU_SLL:    y_o = a_i << b_i[4:0];
            ALU_SLT:    y_o = {31'd0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU:   y_o = {31'd0, a_i < b_i};
            ALU_XOR:    y_o = a_i ^ b_i;
            ALU_SRL:    y_o = a_i >> b_i[4:0];
            ALU_SRA:    y_o = 32'($signed(a_i) >>> b_i[4:0]);
            ALU_OR:     y_o = a_i | b_i;
            ALU_AND:    y_o = a_i & b_i;
            ALU_MUL:    y_o = prod[31:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:
                        y_o = prod[63:32];
            ALU_DIV:    y_o = div_zero ? 32'hFFFF_FFFF :
                              div_ovf  ? 32'h8000_0000 : 32'($signed(a_i) / $signed(b_i));
            ALU_DIVU:   y_o = div_zero ? 32'hFFFF_FFFF : a_i / b_i;
            ALU_REM:    y_o = div_zero ? a_i :
                              div_ovf  ? 32'd0 : 32'($signed(a_i) % $signed(b_i));
            ALU_REMU:   y_o = div_zero ? a_i : a_i % b_i;
            default:    y_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// In-order RV32IM pipeline (ID, EX, MEM, WB behind an external fetch unit).
// Register file and forwarding live here; arithmetic is in cpu_alu.
// BUSYWAIT freezes every pipeline register and the register file.
module cpu
    import cpu_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] PC,
    input  logic [31:0] INSTRUCTION,
    input  logic [31:0] READ_DATA,
    input  logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [31:0] MEM_WRITE_DATA,
    output logic [31:0] MEM_ADDRESS
);

    if_id_t  if_id_q,  if_id_d;
    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    logic [31:0] regs_q [32];
    logic [31:0] INSTRUCTION_OUT, DATA1, DATA2, WRITE_DATA;
    logic [31:0] fwd_rs1, fwd_rs2, op_a, op_b, alu_y;

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_u;
    logic        wb_en;

    assign if_id_d         = '{pc: PC, instr: INSTRUCTION};
    assign INSTRUCTION_OUT = if_id_q.instr;
    assign opcode = INSTRUCTION_OUT[6:0];
    assign rd     = INSTRUCTION_OUT[11:7];
    assign funct3 = INSTRUCTION_OUT[14:12];
    assign rs1    = INSTRUCTION_OUT[19:15];
    assign rs2    = INSTRUCTION_OUT[24:20];
    assign funct7 = INSTRUCTION_OUT[31:25];
    assign imm_i  = {{20{INSTRUCTION_OUT[31]}}, INSTRUCTION_OUT[31:20]};
    assign imm_s  = {{20{INSTRUCTION_OUT[31]}}, INSTRUCTION_OUT[31:25], INSTRUCTION_OUT[11:7]};
    assign imm_u  = {INSTRUCTION_OUT[31:12], 12'd0};

    assign WRITE_DATA = mem_wb_q.result;
    assign wb_en      = mem_wb_q.reg_write && (mem_wb_q.rd != 5'd0);

    // Register read with write-before-read bypass from the WB stage.
    always_comb begin
        DATA1 = regs_q[rs1];
        DATA2 = regs_q[rs2];
        if (wb_en && mem_wb_q.rd == rs1) DATA1 = WRITE_DATA;
        if (wb_en && mem_wb_q.rd == rs2) DATA2 = WRITE_DATA;
        if (rs1 == 5'd0) DATA1 = 32'd0;
        if (rs2 == 5'd0) DATA2 = 32'd0;
    end

    // Decode; anything unrecognised leaves reg_write/mem_* low and retires as a bubble.
    always_comb begin
        id_ex_d         = '0;
        id_ex_d.pc      = if_id_q.pc;
        id_ex_d.rs1_val = DATA1;
        id_ex_d.rs2_val = DATA2;
        id_ex_d.rs1     = rs1;
        id_ex_d.rs2     = rs2;
        id_ex_d.rd      = rd;
        id_ex_d.funct3  = funct3;
        id_ex_d.alu_op  = ALU_ADD;
        id_ex_d.src_a   = SRC_A_RS1;
        id_ex_d.src_b   = SRC_B_IMM;
        case (opcode)
            OPC_LUI: begin
                id_ex_d.src_a     = SRC_A_ZERO;
                id_ex_d.imm       = imm_u;
                id_ex_d.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                id_ex_d.src_a     = SRC_A_PC;
                id_ex_d.imm       = imm_u;
                id_ex_d.reg_write = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                id_ex_d.src_a     = SRC_A_PC;
                id_ex_d.src_b     = SRC_B_FOUR;
                id_ex_d.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                id_ex_d.imm = imm_i;
                if (funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}) begin
                    id_ex_d.reg_write = 1'b1;
                    id_ex_d.mem_read  = 1'b1;
                end
            end
            OPC_STORE: begin
                id_ex_d.imm       = imm_s;
                id_ex_d.mem_write = (funct3 inside {F3_LB, F3_LH, F3_LW});
            end
            OPC_IMM: begin
                id_ex_d.imm    = imm_i;
                id_ex_d.alu_op = base_op(funct3);
                if (funct3 == F3_SLL) begin
                    id_ex_d.reg_write = (funct7 == F7_BASE);
                end else if (funct3 == F3_SR) begin
                    id_ex_d.reg_write = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    if (funct7 == F7_ALT) id_ex_d.alu_op = ALU_SRA;
                end else begin
                    id_ex_d.reg_write = 1'b1;
                end
            end
            OPC_REG: begin
                id_ex_d.src_b = SRC_B_RS2;
                if (funct7 == F7_MULDIV) begin
                    id_ex_d.alu_op    = muldiv_op(funct3);
                    id_ex_d.reg_write = 1'b1;
                end else if (funct7 == F7_BASE) begin
                    id_ex_d.alu_op    = base_op(funct3);
                    id_ex_d.reg_write = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
                    id_ex_d.alu_op    = ALU_SUB;
                    id_ex_d.reg_write = 1'b1;
                end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
                    id_ex_d.alu_op    = ALU_SRA;
                    id_ex_d.reg_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // EX operand forwarding: EX/MEM is younger, so it overrides MEM/WB.
    always_comb begin
        fwd_rs1 = id_ex_q.rs1_val;
        fwd_rs2 = id_ex_q.rs2_val;
        if (wb_en && mem_wb_q.rd == id_ex_q.rs1) fwd_rs1 = WRITE_DATA;
        if (wb_en && mem_wb_q.rd == id_ex_q.rs2) fwd_rs2 = WRITE_DATA;
        if (ex_mem_q.reg_write && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs1) fwd_rs1 = ex_mem_q.result;
        if (ex_mem_q.reg_write && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs2) fwd_rs2 = ex_mem_q.result;
    end

    // ALU operand selection (PC-relative and PC+4 forms use the latched PC).
    always_comb begin
        case (id_ex_q.src_a)
            SRC_A_PC:   op_a = id_ex_q.pc;
            SRC_A_ZERO: op_a = 32'd0;
            default:    op_a = fwd_rs1;
        endcase
        case (id_ex_q.src_b)
            SRC_B_RS2:  op_b = fwd_rs2;
            SRC_B_FOUR: op_b = 32'd4;
            default:    op_b = id_ex_q.imm;
        endcase
    end

    cpu_alu u_alu (
        .op_i (id_ex_q.alu_op),
        .a_i  (op_a),
        .b_i  (op_b),
        .y_o  (alu_y)
    );

    assign ex_mem_d = '{result:     alu_y,
                        store_data: fwd_rs2,
                        rd:         id_ex_q.rd,
                        funct3:     id_ex_q.funct3,
                        reg_write:  id_ex_q.reg_write,
                        mem_read:   id_ex_q.mem_read,
                        mem_write:  id_ex_q.mem_write};

    assign mem_wb_d = '{result:    ex_mem_q.mem_read ? load_extend(ex_mem_q.funct3, READ_DATA)
                                                     : ex_mem_q.result,
                        rd:        ex_mem_q.rd,
                        reg_write: ex_mem_q.reg_write};

    assign MEM_READ       = ex_mem_q.mem_read;
    assign MEM_WRITE      = ex_mem_q.mem_write;
    assign MEM_ADDRESS    = ex_mem_q.result;
    assign MEM_WRITE_DATA = ex_mem_q.store_data;

    // Pipeline registers: bubbles on reset, frozen while memory is busy.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            if_id_q  <= '0;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else if (!BUSYWAIT) begin
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    // Register file: xi resets to i; x0 never written.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'(i);
        end else if (!BUSYWAIT && wb_en) begin
            regs_q[mem_wb_q.rd] <= WRITE_DATA;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: expected writebacks are queued when an instruction
// is issued and compared when the pipeline delivers them.
module tb_cpu;

    logic        CLK = 1'b0;
    logic        RESET, BUSYWAIT;
    logic [31:0] PC, INSTRUCTION, READ_DATA;
    logic        MEM_READ, MEM_WRITE;
    logic [31:0] MEM_WRITE_DATA, MEM_ADDRESS;

    cpu dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .PC             (PC),
        .INSTRUCTION    (INSTRUCTION),
        .READ_DATA      (READ_DATA),
        .BUSYWAIT       (BUSYWAIT),
        .MEM_READ       (MEM_READ),
        .MEM_WRITE      (MEM_WRITE),
        .MEM_WRITE_DATA (MEM_WRITE_DATA),
        .MEM_ADDRESS    (MEM_ADDRESS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    exp_t wb_q[$];
    exp_t rf_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   pcyc  = 0;

    localparam logic [6:0] R_OP = 7'b0110011, I_OP = 7'b0010011, LD = 7'b0000011;

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, R_OP};
    endfunction

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; pcyc counts only edges where the pipeline advanced.
    task automatic tick();
        @(posedge CLK);
        if (!BUSYWAIT) pcyc++;
        @(negedge CLK);
        while (wb_q.size() > 0 && wb_q[0].due == pcyc) begin
            check($sformatf("wb_data x%0d", wb_q[0].rd), dut.WRITE_DATA, wb_q[0].val);
            void'(wb_q.pop_front());
        end
        while (rf_q.size() > 0 && rf_q[0].due == pcyc) begin
            check($sformatf("regfile x%0d", rf_q[0].rd), dut.regs_q[rf_q[0].rd], rf_q[0].val);
            void'(rf_q.pop_front());
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input bit wr,
                         input logic [4:0] rd, input logic [31:0] val);
        INSTRUCTION = ins;
        PC          = pc;
        if (wr) begin
            wb_q.push_back('{pcyc + 4, rd, val});
            rf_q.push_back('{pcyc + 5, rd, val});
        end
        tick();
        INSTRUCTION = 32'd0;
    endtask

    initial begin
        RESET = 1'b1; BUSYWAIT = 1'b0; PC = 32'd0; INSTRUCTION = 32'd0;
        READ_DATA = 32'hDEAD_BEEF;
        #1 RESET = 1'b0;
        #3;
        check("rst mem_read",  {31'd0, MEM_READ},  32'd0);
        check("rst mem_write", {31'd0, MEM_WRITE}, 32'd0);
        check("rst mem_addr",  MEM_ADDRESS,        32'd0);
        check("rst mem_wdata", MEM_WRITE_DATA,     32'd0);
        #8 RESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("idle mem_read",  {31'd0, MEM_READ},  32'd0);
            check("idle mem_write", {31'd0, MEM_WRITE}, 32'd0);
        end

        // dependency chain, M extension, forwarding from both stages and WB bypass
        issue(r_t(7'h00, 5'd2, 5'd1, 3'd0, 5'd6),   32'h100, 1, 5'd6,  32'h0000_0003);
        issue(r_t(7'h20, 5'd5, 5'd6, 3'd0, 5'd4),   32'h104, 1, 5'd4,  32'hFFFF_FFFE);
        issue(r_t(7'h01, 5'd7, 5'd3, 3'd0, 5'd8),   32'h108, 1, 5'd8,  32'd21);
        issue(r_t(7'h01, 5'd0, 5'd5, 3'd4, 5'd9),   32'h10C, 1, 5'd9,  32'hFFFF_FFFF);
        issue(r_t(7'h01, 5'd0, 5'd5, 3'd6, 5'd10),  32'h110, 1, 5'd10, 32'd5);
        issue({20'h80000, 5'd13, 7'b0110111},       32'h114, 1, 5'd13, 32'h8000_0000);
        issue(i_t(12'hFFF, 5'd0, 3'd0, 5'd14, I_OP), 32'h118, 1, 5'd14, 32'hFFFF_FFFF);
        issue(r_t(7'h01, 5'd14, 5'd13, 3'd4, 5'd15), 32'h11C, 1, 5'd15, 32'h8000_0000);
        issue(r_t(7'h01, 5'd14, 5'd13, 3'd6, 5'd16), 32'h120, 1, 5'd16, 32'd0);
        issue(r_t(7'h01, 5'd14, 5'd13, 3'd1, 5'd17), 32'h124, 1, 5'd17, 32'd0);
        issue(r_t(7'h01, 5'd14, 5'd13, 3'd3, 5'd18), 32'h128, 1, 5'd18, 32'h7FFF_FFFF);
        issue(r_t(7'h01, 5'd13, 5'd14, 3'd2, 5'd19), 32'h12C, 1, 5'd19, 32'hFFFF_FFFF);
        issue(r_t(7'h20, 5'd3, 5'd13, 3'd5, 5'd20),  32'h130, 1, 5'd20, 32'hF000_0000);
        issue(r_t(7'h00, 5'd1, 5'd13, 3'd2, 5'd21),  32'h134, 1, 5'd21, 32'd1);
        issue(r_t(7'h00, 5'd1, 5'd13, 3'd3, 5'd22),  32'h138, 1, 5'd22, 32'd0);
        issue(r_t(7'h01, 5'd3, 5'd13, 3'd5, 5'd11),  32'h13C, 1, 5'd11, 32'h2AAA_AAAA);
        issue({20'h00001, 5'd23, 7'b0010111},       32'h100, 1, 5'd23, 32'h0000_1100);
        issue({20'h00000, 5'd24, 7'b1101111},       32'h200, 1, 5'd24, 32'h0000_0204);
        issue({7'd0, 5'd0, 5'd0, 3'd0, 5'd25, 7'b1100011}, 32'h204, 0, 5'd0, 32'd0);
        issue(i_t(12'd5, 5'd1, 3'd0, 5'd0, I_OP),   32'h208, 0, 5'd0, 32'd0);
        issue(r_t(7'h00, 5'd1, 5'd0, 3'd0, 5'd31),  32'h20C, 1, 5'd31, 32'd1);
        repeat (6) tick();
        check("branch no write x25", dut.regs_q[25], 32'd25);

        // loads
        issue(i_t(12'd8, 5'd1, 3'd2, 5'd7, LD), 32'h300, 1, 5'd7, 32'hDEAD_BEEF);
        tick(); tick();
        check("lw mem_read",  {31'd0, MEM_READ},  32'd1);
        check("lw mem_addr",  MEM_ADDRESS,        32'd9);
        check("lw mem_write", {31'd0, MEM_WRITE}, 32'd0);
        tick();
        check("lw read pulse end", {31'd0, MEM_READ}, 32'd0);
        issue(i_t(12'd8, 5'd1, 3'd0, 5'd7,  LD), 32'h304, 1, 5'd7,  32'hFFFF_FFEF);
        issue(i_t(12'd8, 5'd1, 3'd4, 5'd12, LD), 32'h308, 1, 5'd12, 32'h0000_00EF);
        issue(i_t(12'd8, 5'd1, 3'd1, 5'd26, LD), 32'h30C, 1, 5'd26, 32'hFFFF_BEEF);
        issue(i_t(12'd8, 5'd1, 3'd5, 5'd27, LD), 32'h310, 1, 5'd27, 32'h0000_BEEF);
        repeat (6) tick();

        // stores (rd field of the store encodes imm and must not be written)
        issue(s_t(12'd4, 5'd3, 5'd2, 3'd2), 32'h400, 0, 5'd0, 32'd0);
        tick(); tick();
        check("sw mem_write", {31'd0, MEM_WRITE}, 32'd1);
        check("sw mem_addr",  MEM_ADDRESS,        32'd6);
        check("sw mem_wdata", MEM_WRITE_DATA,     32'd3);
        check("sw mem_read",  {31'd0, MEM_READ},  32'd0);
        tick();
        check("sw write pulse end", {31'd0, MEM_WRITE}, 32'd0);
        issue(i_t(12'h123, 5'd0, 3'd0, 5'd28, I_OP), 32'h404, 1, 5'd28, 32'h0000_0123);
        issue(s_t(12'd0, 5'd28, 5'd0, 3'd0),        32'h408, 0, 5'd0,  32'd0);
        tick(); tick();
        check("sb fwd mem_wdata", MEM_WRITE_DATA, 32'h0000_0123);
        check("sb fwd mem_addr",  MEM_ADDRESS,    32'd0);
        repeat (6) tick();
        check("store no write x4", dut.regs_q[4], 32'hFFFF_FFFE);

        // memory stall during a load
        issue(i_t(12'd8, 5'd1, 3'd2, 5'd29, LD), 32'h500, 1, 5'd29, 32'hDEAD_BEEF);
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("busy mem_read %0d", i), {31'd0, MEM_READ}, 32'd1);
            check($sformatf("busy mem_addr %0d", i), MEM_ADDRESS,       32'd9);
            if (i < 2) begin
                BUSYWAIT = 1'b1;
                tick();
            end
        end
        BUSYWAIT = 1'b0;
        tick();
        check("busy read released", {31'd0, MEM_READ}, 32'd0);
        repeat (4) tick();

        // reset while an ALU op sits in WB and a store sits in MEM
        issue(i_t(12'h077, 5'd0, 3'd0, 5'd30, I_OP), 32'h600, 0, 5'd0, 32'd0);
        issue(s_t(12'd4, 5'd3, 5'd2, 3'd2),          32'h604, 0, 5'd0, 32'd0);
        tick(); tick();
        check("pre-reset mem_write", {31'd0, MEM_WRITE}, 32'd1);
        #2 RESET = 1'b0;
        #1;
        check("async rst mem_write", {31'd0, MEM_WRITE}, 32'd0);
        check("async rst mem_addr",  MEM_ADDRESS,        32'd0);
        check("async rst mem_wdata", MEM_WRITE_DATA,     32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post-reset mem_write", {31'd0, MEM_WRITE}, 32'd0);
        end
        check("discarded x30", dut.regs_q[30], 32'd30);
        check("reload x6",     dut.regs_q[6],  32'd6);
        check("reload x7",     dut.regs_q[7],  32'd7);
        check("scoreboard drained", 32'(wb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
